// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types and constants for the RGB sequencer.
// Holds the color table, index type, period limits and mode enum.
package rgb_pkg;

  typedef logic [2:0] color_idx_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    MODE_MANUAL,
    MODE_AUTO
  } mode_t;

  localparam color_idx_t COLOR_IDX_MAX = 3'd6;
  localparam color_idx_t COLOR_IDX_RST = 3'd3;

  localparam logic [14:0] PERIOD_RST  = 15'd700;
  localparam logic [14:0] PERIOD_STEP = 15'd200;
  localparam logic [14:0] PERIOD_LO   = 15'd510;
  localparam logic [14:0] PERIOD_HI   = 15'd16384;

  function automatic rgb_t color_lut(input color_idx_t idx);
    rgb_t c;
    case (idx)
      3'd0:    c = '{8'd255, 8'd0,   8'd0};
      3'd1:    c = '{8'd255, 8'd165, 8'd0};
      3'd2:    c = '{8'd255, 8'd255, 8'd0};
      3'd3:    c = '{8'd255, 8'd255, 8'd255};
      3'd4:    c = '{8'd0,   8'd255, 8'd0};
      3'd5:    c = '{8'd0,   8'd0,   8'd255};
      3'd6:    c = '{8'd160, 8'd32,  8'd240};
      default: c = '{8'd0,   8'd0,   8'd0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rgb_seq_ctrl_btn.sv
// btn_cond: 2-flop synchronizer, debouncer and press detector.
// Ports: clk, rst (async high), raw button in, press one-cycle pulse out.
module btn_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync     <= {sync[0], raw};
      stable_d <= stable;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Nth consecutive differing cycle: accept the new level.
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Rising edge of the debounced level only; releases are silent.
  assign press = stable & ~stable_d;

endmodule

// File: rtl/rgb_seq_ctrl.sv
// rgb_seq_ctrl: button-driven color/brightness sequencer for a PWM LED.
// Ports: clk100mhz, rst (async high), btnl/c/r/u/d raw buttons;
// color_idx, red/green/blue, period, cfg_valid, auto_on registered outputs.
// Optional auto-cycle mode is built when RGB_AUTO_CYCLE_EN is defined.
module rgb_seq_ctrl
  import rgb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned AUTO_TICKS      = 100000000
) (
  input  logic        clk100mhz,
  input  logic        rst,
  input  logic        btnl,
  input  logic        btnc,
  input  logic        btnr,
  input  logic        btnu,
  input  logic        btnd,
  output color_idx_t  color_idx,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [14:0] period,
  output logic        cfg_valid,
  output logic        auto_on
);

  logic [4:0] raw;
  logic [4:0] press;

  assign raw = {btnd, btnu, btnr, btnc, btnl};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_cond #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk100mhz),
      .rst  (rst),
      .raw  (raw[i]),
      .press(press[i])
    );
  end

  logic       pl, pc, pr, pu, pd;
  logic [2:0] cp;
  logic       tick_step;

  assign pl = press[0];
  assign pc = press[1];
  assign pr = press[2];
  assign pu = press[3];
  assign pd = press[4];
  assign cp = {pr, pc, pl};

  color_idx_t  idx_nxt;
  logic [14:0] per_nxt;

  always_comb begin
    idx_nxt = color_idx;
    per_nxt = period;
    // Simultaneous color presses fall to default: no change.
    case (cp)
      3'b001: if (color_idx != COLOR_IDX_MAX) idx_nxt = color_idx + 3'd1;
      3'b010: idx_nxt = COLOR_IDX_RST;
      3'b100: if (color_idx != 3'd0) idx_nxt = color_idx - 3'd1;
      3'b000: begin
        if (tick_step) begin
          idx_nxt = (color_idx == COLOR_IDX_MAX) ? 3'd0
                                                 : color_idx + 3'd1;
        end
      end
      default: ;
    endcase
    case ({pd, pu})
      2'b01: if (period > PERIOD_LO) per_nxt = period - PERIOD_STEP;
      2'b10: if (period < PERIOD_HI) per_nxt = period + PERIOD_STEP;
      default: ;
    endcase
  end

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      color_idx          <= COLOR_IDX_RST;
      {red, green, blue} <= color_lut(COLOR_IDX_RST);
      period             <= PERIOD_RST;
      cfg_valid          <= 1'b0;
    end else begin
      color_idx          <= idx_nxt;
      // Table driven from the next index so rgb never lags color_idx.
      {red, green, blue} <= color_lut(idx_nxt);
      period             <= per_nxt;
      cfg_valid          <= (idx_nxt != color_idx) ||
                            (per_nxt != period);
    end
  end

`ifdef RGB_AUTO_CYCLE_EN
  localparam int TW = $clog2(AUTO_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(AUTO_TICKS - 1);

  mode_t         mode;
  logic [TW-1:0] tick;
  logic          toggle;
  logic          color_press;

  assign toggle      = pl & pr;
  assign color_press = |cp;
  assign tick_step   = (mode == MODE_AUTO) && (tick == TICK_LAST);

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      mode    <= MODE_MANUAL;
      auto_on <= 1'b0;
      tick    <= '0;
    end else begin
      case (mode)
        MODE_MANUAL: begin
          if (toggle) begin
            mode    <= MODE_AUTO;
            auto_on <= 1'b1;
          end
        end
        MODE_AUTO: begin
          if (toggle) begin
            mode    <= MODE_MANUAL;
            auto_on <= 1'b0;
          end
        end
        default: begin
          mode    <= MODE_MANUAL;
          auto_on <= 1'b0;
        end
      endcase
      // Any color press or mode change restarts the step interval.
      if (color_press || mode == MODE_MANUAL || tick == TICK_LAST) begin
        tick <= '0;
      end else begin
        tick <= tick + TW'(1);
      end
    end
  end
`else
  assign tick_step = 1'b0;
  assign auto_on   = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// tb_rgb_seq_ctrl: scoreboard bench for rgb_seq_ctrl.
// Stimulus pushes expected cfg_valid snapshots; a monitor pops them.
module tb_rgb_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        btnl, btnc, btnr, btnu, btnd;
  logic [2:0]  color_idx;
  logic [7:0]  red, green, blue;
  logic [14:0] period;
  logic        cfg_valid;
  logic        auto_on;

  rgb_seq_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_TICKS     (16)
  ) dut (
    .clk100mhz(clk),
    .rst      (rst),
    .btnl     (btnl),
    .btnc     (btnc),
    .btnr     (btnr),
    .btnu     (btnu),
    .btnd     (btnd),
    .color_idx(color_idx),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .period   (period),
    .cfg_valid(cfg_valid),
    .auto_on  (auto_on)
  );

  typedef struct {
    int idx;
    int r;
    int g;
    int b;
    int per;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   pulses = 0;

  int tab_r [7] = '{255, 255, 255, 255, 0,   0,   160};
  int tab_g [7] = '{0,   165, 255, 255, 255, 0,   32};
  int tab_b [7] = '{0,   0,   0,   255, 0,   255, 240};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(int idx, int per);
    exp_t e;
    e.idx = idx;
    e.r   = tab_r[idx];
    e.g   = tab_g[idx];
    e.b   = tab_b[idx];
    e.per = per;
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cfg_valid) begin
      pulses++;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_cfg_valid: got idx=%0d period=%0d, expected no pulse",
                 color_idx, period);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("mon_idx", int'(color_idx), e.idx);
        check("mon_red", int'(red), e.r);
        check("mon_green", int'(green), e.g);
        check("mon_blue", int'(blue), e.b);
        check("mon_period", int'(period), e.per);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // m = {d, u, r, c, l}
  task automatic drive(logic [4:0] m);
    {btnd, btnu, btnr, btnc, btnl} = m;
  endtask

  task automatic press(logic [4:0] m, int hold);
    drive(m);
    cyc(hold);
    drive(5'b0);
    cyc(12);
  endtask

  task automatic wait_drain(int limit, string name);
    for (int i = 0; i < limit; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    check(name, sbq.size(), 0);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_idx"}, int'(color_idx), 3);
    check({tag, "_red"}, int'(red), 255);
    check({tag, "_green"}, int'(green), 255);
    check({tag, "_blue"}, int'(blue), 255);
    check({tag, "_period"}, int'(period), 700);
    check({tag, "_cfg_valid"}, int'(cfg_valid), 0);
    check({tag, "_auto_on"}, int'(auto_on), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    rst = 1'b1;
    drive(5'b0);
    cyc(3);
    check_reset("reset");
    rst = 1'b0;
    cyc(2);

    // btnu twice: 700 -> 500, then saturated at 500
    sbq.push_back(mk(3, 500));
    press(5'b01000, 8);
    wait_drain(20, "drain_btnu");
    press(5'b01000, 8);
    check("period_sat_lo", int'(period), 500);

    // four btnl presses: 4, 5, 6, 6
    p0 = pulses;
    sbq.push_back(mk(4, 500));
    sbq.push_back(mk(5, 500));
    sbq.push_back(mk(6, 500));
    repeat (4) press(5'b00001, 8);
    wait_drain(20, "drain_btnl");
    check("btnl_idx", int'(color_idx), 6);
    check("btnl_red", int'(red), 160);
    check("btnl_green", int'(green), 32);
    check("btnl_blue", int'(blue), 240);
    check("btnl_pulses", pulses - p0, 3);

    // 2-cycle btnc glitch is filtered
    drive(5'b00010);
    cyc(2);
    drive(5'b0);
    cyc(12);
    check("glitch_idx", int'(color_idx), 6);

    sbq.push_back(mk(3, 500));
    press(5'b00010, 8);
    p0 = pulses;
    sbq.push_back(mk(2, 500));
    press(5'b00100, 10);
    wait_drain(20, "drain_btnr");
    check("btnr_idx", int'(color_idx), 2);
    check("btnr_red", int'(red), 255);
    check("btnr_green", int'(green), 255);
    check("btnr_blue", int'(blue), 0);
    check("btnr_pulses", pulses - p0, 1);

    // btnu+btnd cancel, btnl applies in the same cycle
    sbq.push_back(mk(3, 500));
    press(5'b00010, 8);
    p0 = pulses;
    sbq.push_back(mk(4, 500));
    press(5'b11001, 8);
    wait_drain(20, "drain_combo");
    check("combo_period", int'(period), 500);
    check("combo_idx", int'(color_idx), 4);
    check("combo_pulses", pulses - p0, 1);

    rst = 1'b1;
    cyc(2);
    check_reset("reset2");
    rst = 1'b0;
    cyc(2);

    // btnl+btnr together
`ifdef RGB_AUTO_CYCLE_EN
    sbq.push_back(mk(4, 700));
    sbq.push_back(mk(5, 700));
    sbq.push_back(mk(6, 700));
    sbq.push_back(mk(0, 700));
    drive(5'b00101);
    cyc(8);
    drive(5'b0);
    check("auto_on_set", int'(auto_on), 1);
    wait_drain(100, "drain_auto");
    cyc(2);
`else
    drive(5'b00101);
    cyc(8);
    drive(5'b0);
    cyc(40);
    check("noauto_idx", int'(color_idx), 3);
    check("noauto_auto_on", int'(auto_on), 0);
    cyc(2);
`endif

    // reset mid-step with btnd held
    drive(5'b10000);
    cyc(3);
    rst = 1'b1;
    #1;
    check_reset("reset_mid");
    cyc(3);
    rst = 1'b0;
    sbq.push_back(mk(3, 900));
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (period == 15'd900) break;
    end
    check("rst_release_latency", n, 7);
    drive(5'b0);
    cyc(12);
    wait_drain(5, "drain_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb_seq_ctrl.md
RGB_SEQ_CTRL -- requirements
Module: rgb_seq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: stable cycles required to accept a button level change.
REQ-002 Parameter AUTO_TICKS, default 100000000: clock cycles per auto-cycle color step.
REQ-003 Port clk100mhz, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Ports btnl, btnc, btnr, btnu, btnd, input, 1 each: raw asynchronous push buttons, active-high.
REQ-006 Port color_idx, output, 3: current color index, 0..6.
REQ-007 Ports red, green, blue, output, 8 each: duty thresholds for the PWM datapath.
REQ-008 Port period, output, 15: PWM period/brightness value.
REQ-009 Port cfg_valid, output, 1: one-cycle pulse in the cycle any of color_idx or period changes.
REQ-010 Port auto_on, output, 1: auto-cycle mode active; constant 0 when the feature is compiled out.

Function
REQ-011 Each button passes through a 2-flop synchronizer, then a debouncer: a counter clears whenever the synchronized level equals the stable level; the stable level flips after DEBOUNCE_CYCLES consecutive cycles of a differing level.
REQ-012 A press is a one-cycle pulse on a 0->1 transition of a stable level; releases produce no event.
REQ-013 Color table, idx->(r,g,b): 0 (255,0,0); 1 (255,165,0); 2 (255,255,0); 3 (255,255,255); 4 (0,255,0); 5 (0,0,255); 6 (160,32,240).
REQ-014 btnl press: color_idx+1, saturating at 6. btnr press: color_idx-1, saturating at 0. btnc press: color_idx=3.
REQ-015 When more than one of the btnl/btnc/btnr presses occurs in the same cycle, color_idx does not change (except as in REQ-024).
REQ-016 btnu press: period-200 if period>510, else unchanged. btnd press: period+200 if period<16384, else unchanged.
REQ-017 When btnu and btnd presses occur in the same cycle, period does not change.
REQ-018 Color and period updates are independent and may occur in the same cycle.
REQ-019 Outputs are registered: color_idx, red/green/blue, period and cfg_valid update in the first clock edge after the press pulse.
REQ-020 red/green/blue always equal the table entry for color_idx; they never show a mixed or stale value.
REQ-021 cfg_valid is not asserted for a saturated (no-change) press.

Reset
REQ-022 While rst=1: color_idx=3, red=green=blue=255, period=700, cfg_valid=0, auto_on=0. Synchronizers, debouncers (stable level 0), and the tick counter clear.
REQ-023 Reset asserted mid-debounce or mid-auto-step discards the partial count; after release, no press is generated for a button already held until its level is stable for DEBOUNCE_CYCLES.

Configuration
REQ-024 With RGB_AUTO_CYCLE_EN defined: btnl and btnr presses in the same cycle toggle auto_on. While auto_on=1, every AUTO_TICKS cycles color_idx advances (6 wraps to 0) with a cfg_valid pulse. Any manual color press applies per REQ-014 and restarts the tick counter. Toggling auto_on restarts the tick counter.
REQ-025 Without RGB_AUTO_CYCLE_EN: no tick counter; auto_on is tied to 0; simultaneous btnl+btnr is ignored per REQ-015.

Structure
REQ-026 Shared package rgb_pkg holds the color table, COLOR_IDX_MAX=6, COLOR_IDX_RST=3, PERIOD_RST=700, PERIOD_STEP=200, PERIOD_LO=510, PERIOD_HI=16384, and the color index typedef.
REQ-027 Sub-module btn_cond (synchronizer, debouncer, press detect) is instantiated five times; the sequencing FSM and registers stay in rgb_seq_ctrl.

Verification (DEBOUNCE_CYCLES=4, AUTO_TICKS=16)
REQ-028 Reset release, then btnu pressed and released twice -> period 700->500 with one cfg_valid pulse, then stays 500 with no pulse.
REQ-029 Four btnl presses from reset -> color_idx 4,5,6,6; after the last press rgb=(160,32,240) and exactly three cfg_valid pulses occur.
REQ-030 btnc glitch of 2 cycles -> no change. btnr held 10 cycles -> exactly one decrement, to color_idx 2, rgb=(255,255,0).
REQ-031 btnu and btnd pressed on the same cycle with btnl -> period unchanged, color_idx 3->4, one cfg_valid pulse.
REQ-032 Macro on: btnl+btnr together -> auto_on=1; color_idx steps 3->4 every 16 cycles and wraps 6->0. Macro off: same stimulus -> no change.
REQ-033 rst asserted during auto stepping with btnd held -> outputs immediately reset per REQ-022; after release, period becomes 900 only after 4+2 stable cycles.
